npi_arbiter: RTL and testbench

NPI_ARBITER -- requirements
Module: npi_arbiter

---
 rtl/npi_arb_pkg.sv | 11 +
 rtl/npi_rd_latency_pipe.sv | 14 +
 rtl/npi_arbiter.sv | 138 +++++++++++++
 tb/tb_npi_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/npi_arb_pkg.sv
// npi_arb_pkg: arbiter states, size-to-beats decode and NPI width constants
package npi_arb_pkg;
  localparam int NPI_ADDR_W = 32;
  localparam int NPI_DATA_W = 64;
  localparam int NPI_BE_W = 8;
  localparam logic [3:0] SIZE_ILLEGAL = 4'd5;
  typedef enum logic [1:0] {IDLE, WDATA, ADDR, RDATA} state_t;
  function automatic logic [4:0] size_beats(input logic [3:0] size);
    return size >= SIZE_ILLEGAL ? 5'd0 : 5'd1 << size[2:0];
  endfunction
endpackage

// File: rtl/npi_rd_latency_pipe.sv
// npi_rd_latency_pipe: delays the read-fifo pop strobe by 0-2 cycles to form read-valid
module npi_rd_latency_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] lat,
  input  logic       pop,
  output logic       valid
);
  logic [1:0] d;
  always_ff @(posedge clk)
    if (!rst_n) d <= '0;
    else d <= {d[0], pop};
  assign valid = lat == 2'd0 ? pop : lat == 2'd1 ? d[0] : d[1];
endmodule

// File: rtl/npi_arbiter.sv
// npi_arbiter: two-port NPI arbiter; define NPI_ARB_RR_EN for round-robin, otherwise port 0 has fixed priority
module npi_arbiter
  import npi_arb_pkg::*;
#(
  parameter int C_PI_ADDR_WIDTH = NPI_ADDR_W,
  parameter int C_PI_DATA_WIDTH = NPI_DATA_W,
  parameter int C_PI_BE_WIDTH = NPI_BE_W
) (
  input  logic                       FSL_Clk,
  input  logic                       FSL_Rst_N,
  input  logic                       P0_Req,
  input  logic [C_PI_ADDR_WIDTH-1:0] P0_Addr,
  input  logic                       P0_RNW,
  input  logic [3:0]                 P0_Size,
  input  logic [C_PI_DATA_WIDTH-1:0] P0_WrData,
  input  logic [C_PI_BE_WIDTH-1:0]   P0_WrBE,
  input  logic                       P0_WrPush,
  output logic                       P0_WrRdy,
  output logic                       P0_Gnt,
  output logic [C_PI_DATA_WIDTH-1:0] P0_RdData,
  output logic                       P0_RdValid,
  output logic                       P0_Done,
  input  logic                       P1_Req,
  input  logic [C_PI_ADDR_WIDTH-1:0] P1_Addr,
  input  logic                       P1_RNW,
  input  logic [3:0]                 P1_Size,
  input  logic [C_PI_DATA_WIDTH-1:0] P1_WrData,
  input  logic [C_PI_BE_WIDTH-1:0]   P1_WrBE,
  input  logic                       P1_WrPush,
  output logic                       P1_WrRdy,
  output logic                       P1_Gnt,
  output logic [C_PI_DATA_WIDTH-1:0] P1_RdData,
  output logic                       P1_RdValid,
  output logic                       P1_Done,
  output logic [C_PI_ADDR_WIDTH-1:0] XIL_NPI_Addr,
  output logic                       XIL_NPI_AddrReq,
  output logic                       XIL_NPI_RNW,
  output logic [3:0]                 XIL_NPI_Size,
  output logic [C_PI_DATA_WIDTH-1:0] XIL_NPI_WrFIFO_Data,
  output logic [C_PI_BE_WIDTH-1:0]   XIL_NPI_WrFIFO_BE,
  output logic                       XIL_NPI_WrFIFO_Push,
  output logic                       XIL_NPI_RdFIFO_Pop,
  output logic                       XIL_NPI_WrFIFO_Flush,
  output logic                       XIL_NPI_RdFIFO_Flush,
  output logic                       XIL_NPI_RdModWr,
  input  logic                       XIL_NPI_AddrAck,
  input  logic [C_PI_DATA_WIDTH-1:0] XIL_NPI_RdFIFO_Data,
  input  logic                       XIL_NPI_RdFIFO_Empty,
  input  logic [1:0]                 XIL_NPI_RdFIFO_Latency,
  input  logic                       XIL_NPI_WrFIFO_AlmostFull,
  input  logic                       XIL_NPI_InitDone
);
  state_t state, state_n;
  logic own, rnw_q, bad, win, grant, win_rnw, push, pop, rvalid, rv, done, gnt, en, wr_ok;
  logic [C_PI_ADDR_WIDTH-1:0] addr_q;
  logic [3:0] size_q, win_size;
  logic [1:0] lat_q;
  logic [4:0] n, cnt, vcnt;
`ifdef NPI_ARB_RR_EN
  logic ptr;
  assign win = P0_Req && P1_Req ? ptr : P1_Req;
  always_ff @(posedge FSL_Clk)
    if (!FSL_Rst_N) ptr <= 1'b0;
    else if (grant) ptr <= !win;
`else
  assign win = !P0_Req;
`endif
  assign en = FSL_Rst_N;
  assign win_size = win ? P1_Size : P0_Size;
  assign win_rnw = win ? P1_RNW : P0_RNW;
  assign grant = state == IDLE && !bad && XIL_NPI_InitDone && (P0_Req || P1_Req);
  assign n = size_beats(size_q);
  assign wr_ok = state == WDATA && !XIL_NPI_WrFIFO_AlmostFull;
  assign push = wr_ok && (own ? P1_WrPush : P0_WrPush);
  assign pop = state == RDATA && !XIL_NPI_RdFIFO_Empty && cnt < n;
  assign rv = state == RDATA && rvalid;
  assign done = bad || (state == ADDR && XIL_NPI_AddrAck && !rnw_q) || (rv && vcnt == n - 5'd1);
  assign gnt = bad || state != IDLE;
  npi_rd_latency_pipe u_pipe (
    .clk  (FSL_Clk),
    .rst_n(FSL_Rst_N),
    .lat  (lat_q),
    .pop  (pop),
    .valid(rvalid)
  );
  always_comb begin
    state_n = state;
    if (grant && win_size < SIZE_ILLEGAL) state_n = win_rnw ? ADDR : WDATA;
    if (push && cnt == n - 5'd1) state_n = ADDR;
    if (state == ADDR && XIL_NPI_AddrAck) state_n = rnw_q ? RDATA : IDLE;
    if (rv && done) state_n = IDLE;
  end
  always_ff @(posedge FSL_Clk)
    if (!FSL_Rst_N) begin
      state <= IDLE;
      own <= 1'b0;
      addr_q <= '0;
      rnw_q <= 1'b0;
      size_q <= 4'd0;
      lat_q <= 2'd0;
      bad <= 1'b0;
      cnt <= 5'd0;
      vcnt <= 5'd0;
    end else begin
      state <= state_n;
      bad <= grant && win_size >= SIZE_ILLEGAL;
      if (grant) begin
        own <= win;
        addr_q <= win ? P1_Addr : P0_Addr;
        rnw_q <= win_rnw;
        size_q <= win_size;
        lat_q <= XIL_NPI_RdFIFO_Latency;
      end
      cnt <= state_n != state ? 5'd0 : cnt + 5'(push || pop);
      vcnt <= state != RDATA ? 5'd0 : vcnt + 5'(rv);
    end
  assign P0_Gnt = en && gnt && !own;
  assign P1_Gnt = en && gnt && own;
  assign P0_Done = en && done && !own;
  assign P1_Done = en && done && own;
  assign P0_WrRdy = en && wr_ok && !own;
  assign P1_WrRdy = en && wr_ok && own;
  assign P0_RdValid = en && rv && !own;
  assign P1_RdValid = en && rv && own;
  assign P0_RdData = P0_RdValid ? XIL_NPI_RdFIFO_Data : '0;
  assign P1_RdData = P1_RdValid ? XIL_NPI_RdFIFO_Data : '0;
  assign XIL_NPI_AddrReq = en && state == ADDR;
  assign XIL_NPI_Addr = XIL_NPI_AddrReq ? addr_q : '0;
  assign XIL_NPI_RNW = XIL_NPI_AddrReq && rnw_q;
  assign XIL_NPI_Size = XIL_NPI_AddrReq ? size_q : 4'd0;
  assign XIL_NPI_WrFIFO_Data = en && state == WDATA ? (own ? P1_WrData : P0_WrData) : '0;
  assign XIL_NPI_WrFIFO_BE = en && state == WDATA ? (own ? P1_WrBE : P0_WrBE) : '0;
  assign XIL_NPI_WrFIFO_Push = en && push;
  assign XIL_NPI_RdFIFO_Pop = en && pop;
  assign XIL_NPI_WrFIFO_Flush = !en;
  assign XIL_NPI_RdFIFO_Flush = !en;
  assign XIL_NPI_RdModWr = 1'b0;
endmodule

// File: tb/tb_npi_arbiter.sv
// tb_npi_arbiter: directed self-checking bench for npi_arbiter
module tb_npi_arbiter;
`ifdef NPI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst_n;
  logic p0_req, p0_rnw, p0_push, p0_wrrdy, p0_gnt, p0_rdvalid, p0_done;
  logic p1_req, p1_rnw, p1_push, p1_wrrdy, p1_gnt, p1_rdvalid, p1_done;
  logic [31:0] p0_addr, p1_addr, npi_addr;
  logic [3:0] p0_size, p1_size, npi_size;
  logic [63:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, npi_wdata, npi_rdata;
  logic [7:0] p0_be, p1_be, npi_be;
  logic areq, npi_rnw, wpush, rpop, wflush, rflush, rmw;
  logic ack, empty, af, init_done;
  logic [1:0] lat;
  int checks = 0, failures = 0, pushes;
  always #5 clk = ~clk;
  npi_arbiter dut (
    .FSL_Clk(clk), .FSL_Rst_N(rst_n),
    .P0_Req(p0_req), .P0_Addr(p0_addr), .P0_RNW(p0_rnw), .P0_Size(p0_size),
    .P0_WrData(p0_wdata), .P0_WrBE(p0_be), .P0_WrPush(p0_push), .P0_WrRdy(p0_wrrdy),
    .P0_Gnt(p0_gnt), .P0_RdData(p0_rdata), .P0_RdValid(p0_rdvalid), .P0_Done(p0_done),
    .P1_Req(p1_req), .P1_Addr(p1_addr), .P1_RNW(p1_rnw), .P1_Size(p1_size),
    .P1_WrData(p1_wdata), .P1_WrBE(p1_be), .P1_WrPush(p1_push), .P1_WrRdy(p1_wrrdy),
    .P1_Gnt(p1_gnt), .P1_RdData(p1_rdata), .P1_RdValid(p1_rdvalid), .P1_Done(p1_done),
    .XIL_NPI_Addr(npi_addr), .XIL_NPI_AddrReq(areq), .XIL_NPI_RNW(npi_rnw), .XIL_NPI_Size(npi_size),
    .XIL_NPI_WrFIFO_Data(npi_wdata), .XIL_NPI_WrFIFO_BE(npi_be), .XIL_NPI_WrFIFO_Push(wpush),
    .XIL_NPI_RdFIFO_Pop(rpop), .XIL_NPI_WrFIFO_Flush(wflush), .XIL_NPI_RdFIFO_Flush(rflush),
    .XIL_NPI_RdModWr(rmw), .XIL_NPI_AddrAck(ack), .XIL_NPI_RdFIFO_Data(npi_rdata),
    .XIL_NPI_RdFIFO_Empty(empty), .XIL_NPI_RdFIFO_Latency(lat),
    .XIL_NPI_WrFIFO_AlmostFull(af), .XIL_NPI_InitDone(init_done)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; init_done = 1'b1; empty = 1'b1; af = 1'b0; ack = 1'b0; lat = 2'd0; npi_rdata = '0;
    {p0_req, p0_rnw, p0_push, p1_req, p1_rnw, p1_push} = '0;
    {p0_addr, p1_addr, p0_size, p1_size, p0_wdata, p1_wdata, p0_be, p1_be} = '0;
    step();
    step();
    chk("rst_gnt", {p0_gnt, p1_gnt}, 0);
    chk("rst_wflush", wflush, 1);
    chk("rst_rflush", rflush, 1);
    chk("rst_areq", areq, 0);
    chk("rst_rmw", rmw, 0);
    rst_n = 1'b1;
    step();
    chk("flush_release", {wflush, rflush}, 0);
    p0_addr = 32'h0000_1000; p0_rnw = 1'b1; p0_size = 4'd2; lat = 2'd1; p0_req = 1'b1;
    step();
    chk("a_gnt", p0_gnt, 1);
    chk("a_p1gnt", p1_gnt, 0);
    chk("a_areq", areq, 1);
    chk("a_addr", npi_addr, 32'h0000_1000);
    chk("a_rnw", npi_rnw, 1);
    chk("a_size", npi_size, 2);
    step();
    chk("a_areq_hold", areq, 1);
    ack = 1'b1;
    #1 chk("a_ack_nodone", p0_done, 0);
    step();
    ack = 1'b0; empty = 1'b0;
    for (int c = 0; c < 5; c++) begin
      npi_rdata = 64'hA0 + 64'(c);
      #1;
      chk("a_pop", rpop, c < 4);
      chk("a_valid", p0_rdvalid, c >= 1);
      chk("a_rdata", p0_rdata, c >= 1 ? 64'hA0 + 64'(c) : 64'h0);
      chk("a_done", p0_done, c == 4);
      chk("a_gnt_hold", p0_gnt, 1);
      if (c == 4) p0_req = 1'b0;
      step();
    end
    empty = 1'b1;
    #1 chk("a_gnt_drop", p0_gnt, 0);
    p1_addr = 32'h0000_2000; p1_rnw = 1'b0; p1_size = 4'd1; p1_push = 1'b1; p1_be = 8'hF0; p1_req = 1'b1;
    step();
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      af = i >= 1 && i <= 3;
      p1_wdata = 64'hD0 + 64'(i);
      #1;
      chk("b_wrrdy", p1_wrrdy, !af);
      chk("b_push", wpush, !af);
      chk("b_p0_wrrdy", p0_wrrdy, 0);
      chk("b_areq_early", areq, 0);
      if (!af) chk("b_wdata", npi_wdata, 64'hD0 + 64'(i));
      if (!af) chk("b_be", npi_be, 8'hF0);
      if (wpush) pushes++;
      step();
    end
    af = 1'b0; p1_push = 1'b0;
    #1;
    chk("b_pushes", pushes, 2);
    chk("b_areq", areq, 1);
    chk("b_no_push", wpush, 0);
    chk("b_nodone", p1_done, 0);
    ack = 1'b1;
    #1;
    chk("b_done", p1_done, 1);
    chk("b_gnt", p1_gnt, 1);
    p1_req = 1'b0;
    step();
    ack = 1'b0;
    #1 chk("b_gnt_drop", p1_gnt, 0);
    p0_size = 4'd7; p1_size = 4'd7;
    for (int k = 0; k < 4; k++) begin
      p0_req = 1'b1; p1_req = 1'b1;
      step();
      chk("c_p1gnt", p1_gnt, RR ? k[0] : 1'b0);
      chk("c_p0gnt", p0_gnt, RR ? !k[0] : 1'b1);
      chk("c_done", {p1_done, p0_done}, {p1_gnt, p0_gnt});
      p0_req = 1'b0; p1_req = 1'b0;
      step();
    end
    p0_req = 1'b1;
    step();
    chk("d_gnt", p0_gnt, 1);
    chk("d_done", p0_done, 1);
    chk("d_areq", areq, 0);
    p0_req = 1'b0;
    step();
    chk("d_gnt_drop", p0_gnt, 0);
    chk("d_areq_after", areq, 0);
    init_done = 1'b0; p1_size = 4'd5; p1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("e_nogrant", p1_gnt, 0);
    end
    init_done = 1'b1;
    step();
    chk("e_gnt", p1_gnt, 1);
    chk("e_done_sz5", p1_done, 1);
    p1_req = 1'b0;
    step();
    p0_addr = 32'h0000_3000; p0_rnw = 1'b1; p0_size = 4'd3; lat = 2'd0; p0_req = 1'b1;
    step();
    ack = 1'b1;
    #1 chk("f_areq", areq, 1);
    step();
    ack = 1'b0; empty = 1'b0;
    for (int c = 0; c < 2; c++) begin
      npi_rdata = 64'hB0 + 64'(c);
      #1;
      chk("f_pop", rpop, 1);
      chk("f_valid", p0_rdvalid, 1);
      chk("f_rdata", p0_rdata, 64'hB0 + 64'(c));
      step();
    end
    rst_n = 1'b0; p0_req = 1'b0;
    #1;
    chk("f_rst_gnt", p0_gnt, 0);
    chk("f_rst_pop", rpop, 0);
    chk("f_rst_valid", p0_rdvalid, 0);
    chk("f_rst_rdata", p0_rdata, 0);
    chk("f_rst_flush", {wflush, rflush}, 2'b11);
    step();
    chk("f_rst_done", {p0_done, p1_done}, 0);
    chk("f_rst_gnt2", {p0_gnt, p1_gnt}, 0);
    rst_n = 1'b1; empty = 1'b1;
    step();
    chk("f_flush_off", {wflush, rflush}, 0);
    chk("f_idle_done", p0_done, 0);
    p1_addr = 32'h0000_4000; p1_rnw = 1'b1; p1_size = 4'd0; lat = 2'd2; p1_req = 1'b1;
    step();
    chk("g_gnt", p1_gnt, 1);
    chk("g_addr", npi_addr, 32'h0000_4000);
    ack = 1'b1;
    step();
    ack = 1'b0; empty = 1'b0; npi_rdata = 64'hC0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("g_pop", rpop, c == 0);
      chk("g_valid", p1_rdvalid, c == 2);
      chk("g_done", p1_done, c == 2);
      if (c == 2) chk("g_rdata", p1_rdata, 64'hC0);
      if (c == 2) p1_req = 1'b0;
      step();
    end
    empty = 1'b1;
    #1 chk("g_gnt_drop", p1_gnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
